// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle main control unit: opcodes, FSM states,
// instruction classes and datapath mux/ALU select codes.
package ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b111111;
  localparam logic [5:0] OP_ADDI = 6'b110111;
  localparam logic [5:0] OP_LUI  = 6'b110001;
  localparam logic [5:0] OP_LW   = 6'b100001;
  localparam logic [5:0] OP_SW   = 6'b100011;
  localparam logic [5:0] OP_BEQ  = 6'b111011;
  localparam logic [5:0] OP_BNE  = 6'b100101;
  localparam logic [5:0] OP_J    = 6'b100010;
  localparam logic [5:0] OP_JAL  = 6'b100111;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_WBALU  = 4'd6,
    S_WBMEM  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ERR    = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    I_R, I_JR, I_ADDI, I_LUI, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JAL, I_ILL
  } instr_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_R    = 3'b001;
  localparam logic [2:0] ALU_ADDI = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;
  localparam logic [2:0] ALU_BEQ  = 3'b100;
  localparam logic [2:0] ALU_BNE  = 3'b110;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] ASB_RT     = 2'd0;
  localparam logic [1:0] ASB_FOUR   = 2'd1;
  localparam logic [1:0] ASB_IMM    = 2'd2;
  localparam logic [1:0] ASB_IMM_SH = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter: counts unanswered request cycles and flags the
// cycle in which the TIMEOUT-th consecutive wait occurs.
module mc_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic wait_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wait_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This wait cycle is the one that brings the count up to TIMEOUT.
  assign expire_o = wait_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the Lab CPU: steps each instruction through
// fetch/decode/execute/memory/write-back with a memory wait-state timeout.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned TIMEOUT = 255,
  parameter bit          EN_JAL  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               mem_ready_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               iord_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic               branch_o,
  output logic               branch_type_o,
  output logic [1:0]         pc_src_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               reg_write_o,
  output logic [1:0]         reg_dst_o,
  output logic [1:0]         mem_to_reg_o,
  output logic               illegal_o,
  output logic               timeout_o,
  output logic [3:0]         state_o
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   timeout_q, timeout_d;
  instr_t cls;
  logic   mem_wait, expire;

  always_comb begin
    cls = I_ILL;
    if (instr_op_i == OP_W'(OP_R)) begin
      cls = (funct_i == FUNCT_W'(FUNCT_JR)) ? I_JR : I_R;
    end else if (instr_op_i == OP_W'(OP_ADDI)) cls = I_ADDI;
    else if (instr_op_i == OP_W'(OP_LUI))      cls = I_LUI;
    else if (instr_op_i == OP_W'(OP_LW))       cls = I_LW;
    else if (instr_op_i == OP_W'(OP_SW))       cls = I_SW;
    else if (instr_op_i == OP_W'(OP_BEQ))      cls = I_BEQ;
    else if (instr_op_i == OP_W'(OP_BNE))      cls = I_BNE;
    else if (instr_op_i == OP_W'(OP_J))        cls = I_J;
    else if (instr_op_i == OP_W'(OP_JAL))      cls = EN_JAL ? I_JAL : I_ILL;
  end

  // Kept separate from the main decode so the timer path has no apparent loop.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                    && !mem_ready_i;

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_d != state_q),
    .wait_i   (mem_wait),
    .expire_o (expire)
  );

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    timeout_d     = timeout_q;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    iord_o        = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    branch_o      = 1'b0;
    branch_type_o = 1'b0;
    pc_src_o      = PC_SRC_ALU;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = ASB_RT;
    alu_op_o      = ALUOP_W'(ALU_ADD);
    reg_write_o   = 1'b0;
    reg_dst_o     = RD_RT;
    mem_to_reg_o  = M2R_ALUOUT;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = ASB_FOUR;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = S_ERR;
        end
      end
      S_DECODE: begin
        alu_src_b_o = ASB_IMM_SH;
        unique case (cls)
          I_R, I_ADDI, I_LUI, I_LW, I_SW: state_d = S_EXEC;
          I_BEQ, I_BNE:                   state_d = S_BRANCH;
          I_J, I_JAL, I_JR:               state_d = S_JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_ERR;
          end
        endcase
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = (cls == I_R) ? ASB_RT : ASB_IMM;
        if (cls == I_R)         alu_op_o = ALUOP_W'(ALU_R);
        else if (cls == I_ADDI) alu_op_o = ALUOP_W'(ALU_ADDI);
        else if (cls == I_LUI)  alu_op_o = ALUOP_W'(ALU_LUI);
        if (cls == I_LW)        state_d = S_MEMRD;
        else if (cls == I_SW)   state_d = S_MEMWR;
        else                    state_d = S_WBALU;
      end
      S_MEMRD, S_MEMWR: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = (state_q == S_MEMWR);
        if (mem_ready_i) begin
          state_d = (state_q == S_MEMRD) ? S_WBMEM : S_FETCH;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = S_ERR;
        end
      end
      S_WBALU: begin
        reg_write_o = 1'b1;
        reg_dst_o   = (cls == I_R) ? RD_RD : RD_RT;
        state_d     = S_FETCH;
      end
      S_WBMEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o   = 1'b1;
        branch_o      = 1'b1;
        pc_src_o      = PC_SRC_ALUOUT;
        branch_type_o = (cls == I_BNE);
        alu_op_o      = (cls == I_BNE) ? ALUOP_W'(ALU_BNE) : ALUOP_W'(ALU_BEQ);
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = (cls == I_JR) ? PC_SRC_RS : PC_SRC_JUMP;
        if (cls == I_JAL) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = RD_RA;
          mem_to_reg_o = M2R_PC;
        end
        state_d = S_FETCH;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected state/outputs are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_ctrl;

  localparam logic [5:0] OPR  = 6'b111111;
  localparam logic [5:0] ADDI = 6'b110111;
  localparam logic [5:0] LUI  = 6'b110001;
  localparam logic [5:0] LW   = 6'b100001;
  localparam logic [5:0] SW   = 6'b100011;
  localparam logic [5:0] BEQ  = 6'b111011;
  localparam logic [5:0] BNE  = 6'b100101;
  localparam logic [5:0] JMP  = 6'b100010;
  localparam logic [5:0] JAL  = 6'b100111;
  localparam logic [5:0] ILL  = 6'b000000;
  localparam logic [5:0] FADD = 6'b100000;
  localparam logic [5:0] FJR  = 6'b001000;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, branch, btype;
    logic [1:0] pc_src;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst, m2r;
    logic       illegal, timeout;
  } outv_t;

  typedef struct packed {
    logic [3:0] st;
    outv_t      o;
    logic       chk_b;
    logic [3:0] st_b;
    outv_t      o_b;
    int         idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, ready;
  logic [5:0] op_r, funct_r;

  logic a_req, a_we, a_iord, a_irw, a_pcw, a_br, a_bt, a_asa, a_rw, a_ill, a_to;
  logic [1:0] a_pcs, a_asb, a_rd, a_m2r;
  logic [2:0] a_aop;
  logic [3:0] a_st;
  logic b_req, b_we, b_iord, b_irw, b_pcw, b_br, b_bt, b_asa, b_rw, b_ill, b_to;
  logic [1:0] b_pcs, b_asb, b_rd, b_m2r;
  logic [2:0] b_aop;
  logic [3:0] b_st;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   vec = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(6), .FUNCT_W(6), .ALUOP_W(3), .TIMEOUT(3), .EN_JAL(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .instr_op_i(op_r), .funct_i(funct_r), .mem_ready_i(ready),
    .mem_req_o(a_req), .mem_we_o(a_we), .iord_o(a_iord), .ir_write_o(a_irw),
    .pc_write_o(a_pcw), .branch_o(a_br), .branch_type_o(a_bt), .pc_src_o(a_pcs),
    .alu_src_a_o(a_asa), .alu_src_b_o(a_asb), .alu_op_o(a_aop), .reg_write_o(a_rw),
    .reg_dst_o(a_rd), .mem_to_reg_o(a_m2r), .illegal_o(a_ill), .timeout_o(a_to),
    .state_o(a_st));

  multicycle_ctrl #(.OP_W(6), .FUNCT_W(6), .ALUOP_W(3), .TIMEOUT(3), .EN_JAL(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .instr_op_i(op_r), .funct_i(funct_r), .mem_ready_i(ready),
    .mem_req_o(b_req), .mem_we_o(b_we), .iord_o(b_iord), .ir_write_o(b_irw),
    .pc_write_o(b_pcw), .branch_o(b_br), .branch_type_o(b_bt), .pc_src_o(b_pcs),
    .alu_src_a_o(b_asa), .alu_src_b_o(b_asb), .alu_op_o(b_aop), .reg_write_o(b_rw),
    .reg_dst_o(b_rd), .mem_to_reg_o(b_m2r), .illegal_o(b_ill), .timeout_o(b_to),
    .state_o(b_st));

  function automatic outv_t o_idle();
    outv_t o = '0;
    return o;
  endfunction
  function automatic outv_t o_fetch(input logic rdy);
    outv_t o = '0;
    o.mem_req = 1'b1; o.asb = 2'd1; o.ir_write = rdy; o.pc_write = rdy;
    return o;
  endfunction
  function automatic outv_t o_decode();
    outv_t o = '0;
    o.asb = 2'd3;
    return o;
  endfunction
  function automatic outv_t o_exec(input logic [1:0] asb, input logic [2:0] aop);
    outv_t o = '0;
    o.asa = 1'b1; o.asb = asb; o.alu_op = aop;
    return o;
  endfunction
  function automatic outv_t o_mem(input logic we);
    outv_t o = '0;
    o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = we;
    return o;
  endfunction
  function automatic outv_t o_wbalu(input logic [1:0] rd);
    outv_t o = '0;
    o.reg_write = 1'b1; o.reg_dst = rd;
    return o;
  endfunction
  function automatic outv_t o_wbmem();
    outv_t o = '0;
    o.reg_write = 1'b1; o.m2r = 2'd1;
    return o;
  endfunction
  function automatic outv_t o_branch(input logic bt, input logic [2:0] aop);
    outv_t o = '0;
    o.asa = 1'b1; o.branch = 1'b1; o.pc_src = 2'd1; o.btype = bt; o.alu_op = aop;
    return o;
  endfunction
  function automatic outv_t o_jump(input logic [1:0] pcs, input logic jal);
    outv_t o = '0;
    o.pc_write = 1'b1; o.pc_src = pcs;
    if (jal) begin
      o.reg_write = 1'b1; o.reg_dst = 2'd2; o.m2r = 2'd2;
    end
    return o;
  endfunction
  function automatic outv_t o_err(input logic ill, input logic to);
    outv_t o = '0;
    o.illegal = ill; o.timeout = to;
    return o;
  endfunction

  task automatic cyc2(input logic rst, input logic rdy, input logic [5:0] op,
                      input logic [5:0] fn, input logic [3:0] st, input outv_t o,
                      input logic chk_b, input logic [3:0] st_b, input outv_t o_b);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; ready = rdy; op_r = op; funct_r = fn;
    e.st = st; e.o = o; e.chk_b = chk_b; e.st_b = st_b; e.o_b = o_b; e.idx = vec;
    vec++;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic rdy, input logic [5:0] op,
                     input logic [5:0] fn, input logic [3:0] st, input outv_t o);
    cyc2(rst, rdy, op, fn, st, o, 1'b0, 4'd0, '0);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t  e;
      outv_t act;
      e = sb.pop_front();
      act = '{a_req, a_we, a_iord, a_irw, a_pcw, a_br, a_bt, a_pcs, a_asa, a_asb,
              a_aop, a_rw, a_rd, a_m2r, a_ill, a_to};
      n_checks++;
      if (a_st === e.st) n_pass++;
      else $display("FAIL state_a[vec %0d]: got %0d want %0d", e.idx, a_st, e.st);
      n_checks++;
      if (act === e.o) n_pass++;
      else $display("FAIL outputs_a[vec %0d]: got %h want %h", e.idx, act, e.o);
      if (e.chk_b) begin
        act = '{b_req, b_we, b_iord, b_irw, b_pcw, b_br, b_bt, b_pcs, b_asa, b_asb,
                b_aop, b_rw, b_rd, b_m2r, b_ill, b_to};
        n_checks++;
        if (b_st === e.st_b) n_pass++;
        else $display("FAIL state_b[vec %0d]: got %0d want %0d", e.idx, b_st, e.st_b);
        n_checks++;
        if (act === e.o_b) n_pass++;
        else $display("FAIL outputs_b[vec %0d]: got %h want %h", e.idx, act, e.o_b);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ready = 1'b0; op_r = '0; funct_r = '0;
    repeat (2) @(posedge clk);
    cyc(0, 0, ILL, 0, 0, o_idle());
    cyc(1, 0, ILL, 0, 0, o_idle());
    // R-type add, ready tied high
    cyc(1, 1, OPR, FADD, 1, o_fetch(1));
    cyc(1, 1, OPR, FADD, 2, o_decode());
    cyc(1, 1, OPR, FADD, 3, o_exec(2'd0, 3'b001));
    cyc(1, 1, OPR, FADD, 6, o_wbalu(2'd1));
    // lw with two data wait cycles
    cyc(1, 1, LW, 0, 1, o_fetch(1));
    cyc(1, 1, LW, 0, 2, o_decode());
    cyc(1, 1, LW, 0, 3, o_exec(2'd2, 3'b000));
    cyc(1, 0, LW, 0, 4, o_mem(0));
    cyc(1, 0, LW, 0, 4, o_mem(0));
    cyc(1, 1, LW, 0, 4, o_mem(0));
    cyc(1, 1, LW, 0, 7, o_wbmem());
    // addi, lui
    cyc(1, 1, ADDI, 0, 1, o_fetch(1));
    cyc(1, 1, ADDI, 0, 2, o_decode());
    cyc(1, 1, ADDI, 0, 3, o_exec(2'd2, 3'b010));
    cyc(1, 1, ADDI, 0, 6, o_wbalu(2'd0));
    cyc(1, 1, LUI, 0, 1, o_fetch(1));
    cyc(1, 1, LUI, 0, 2, o_decode());
    cyc(1, 1, LUI, 0, 3, o_exec(2'd2, 3'b011));
    cyc(1, 1, LUI, 0, 6, o_wbalu(2'd0));
    // sw with one wait
    cyc(1, 1, SW, 0, 1, o_fetch(1));
    cyc(1, 1, SW, 0, 2, o_decode());
    cyc(1, 1, SW, 0, 3, o_exec(2'd2, 3'b000));
    cyc(1, 0, SW, 0, 5, o_mem(1));
    cyc(1, 1, SW, 0, 5, o_mem(1));
    // bne, beq, jr, j
    cyc(1, 1, BNE, 0, 1, o_fetch(1));
    cyc(1, 1, BNE, 0, 2, o_decode());
    cyc(1, 1, BNE, 0, 8, o_branch(1, 3'b110));
    cyc(1, 1, BEQ, 0, 1, o_fetch(1));
    cyc(1, 1, BEQ, 0, 2, o_decode());
    cyc(1, 1, BEQ, 0, 8, o_branch(0, 3'b100));
    cyc(1, 1, OPR, FJR, 1, o_fetch(1));
    cyc(1, 1, OPR, FJR, 2, o_decode());
    cyc(1, 1, OPR, FJR, 9, o_jump(2'd3, 0));
    cyc(1, 1, JMP, 0, 1, o_fetch(1));
    cyc(1, 1, JMP, 0, 2, o_decode());
    cyc(1, 1, JMP, 0, 9, o_jump(2'd2, 0));
    // TIMEOUT-1 fetch waits then ready: no timeout; then jal (B has jal disabled)
    cyc(1, 0, JAL, 0, 1, o_fetch(0));
    cyc(1, 0, JAL, 0, 1, o_fetch(0));
    cyc(1, 1, JAL, 0, 1, o_fetch(1));
    cyc(1, 1, JAL, 0, 2, o_decode());
    cyc2(1, 1, JAL, 0, 9, o_jump(2'd2, 1), 1'b1, 4'd10, o_err(1, 0));
    // reset asserted mid-wait in MEMWR
    cyc(1, 1, SW, 0, 1, o_fetch(1));
    cyc(1, 1, SW, 0, 2, o_decode());
    cyc(1, 1, SW, 0, 3, o_exec(2'd2, 3'b000));
    cyc(0, 0, SW, 0, 5, o_mem(1));
    cyc2(1, 0, SW, 0, 0, o_idle(), 1'b1, 4'd0, o_idle());
    // illegal opcode: ERR is sticky until reset, ready ignored there
    cyc(1, 1, ILL, 0, 1, o_fetch(1));
    cyc(1, 1, ILL, 0, 2, o_decode());
    cyc(1, 1, ILL, 0, 10, o_err(1, 0));
    cyc(0, 1, ILL, 0, 10, o_err(1, 0));
    cyc(1, 0, ILL, 0, 0, o_idle());
    // timeout: three unanswered fetch cycles with TIMEOUT=3
    cyc(1, 0, ADDI, 0, 1, o_fetch(0));
    cyc(1, 0, ADDI, 0, 1, o_fetch(0));
    cyc(1, 0, ADDI, 0, 1, o_fetch(0));
    cyc(1, 1, ADDI, 0, 10, o_err(0, 1));
    cyc(1, 0, ADDI, 0, 10, o_err(0, 1));
    cyc(0, 0, ADDI, 0, 10, o_err(0, 1));
    cyc(1, 0, ADDI, 0, 0, o_idle());
    cyc(1, 0, ADDI, 0, 1, o_fetch(0));

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main control unit for the Lab CPU. It replaces the single-cycle combinational decoder with a registered state machine that steps each instruction through fetch, decode, execute, memory and write-back. It handshakes with a variable-latency unified instruction/data memory and enforces a parameterised wait-state timeout. It sits between the instruction register and the datapath muxes, ALU control, register file and PC.

## Interface
Parameters:
- OP_W, 6, opcode width
- FUNCT_W, 6, funct width
- ALUOP_W, 3, ALU-op width driven to ALU control
- TIMEOUT, 255, maximum cycles spent waiting for mem_ready_i before the error state (≥1)
- EN_JAL, 1, when 0, opcode jal decodes as illegal

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- instr_op_i  in  OP_W  opcode from the instruction register
- funct_i  in  FUNCT_W  funct from the instruction register
- mem_ready_i  in  1  memory access complete this cycle
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  write (sw)
- iord_o  out  1  memory address source: 0 = PC, 1 = ALU result
- ir_write_o  out  1  load the instruction register
- pc_write_o  out  1  unconditional PC load
- branch_o  out  1  conditional PC load, qualified by the ALU zero flag in the datapath
- branch_type_o  out  1  0 = beq, 1 = bne
- pc_src_o  out  2  0 = ALU (PC+4), 1 = ALUOut (branch target), 2 = jump target, 3 = rs (jr)
- alu_src_a_o  out  1  0 = PC, 1 = rs
- alu_src_b_o  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- alu_op_o  out  ALUOP_W  R 001, lw/sw 000, beq 100, bne 110, addi 010, lui 011, PC arithmetic 000
- reg_write_o  out  1  register file write
- reg_dst_o  out  2  0 = rt, 1 = rd, 2 = $31
- mem_to_reg_o  out  2  0 = ALUOut, 1 = MDR, 2 = PC
- illegal_o  out  1  sticky: an illegal opcode was decoded
- timeout_o  out  1  sticky: the memory wait limit was exceeded
- state_o  out  4  current state code, for debug

## Operation
- Opcodes: R 111111 (jr = funct 001000), addi 110111, lui 110001, lw 100001, sw 100011, beq 111011, bne 100101, j 100010, jal 100111. Any other opcode is illegal.
- States and codes: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEMRD 4, MEMWR 5, WBALU 6, WBMEM 7, BRANCH 8, JUMP 9, ERR 10.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=000.
  - When mem_ready_i=1, also assert ir_write=1 and pc_write=1 with pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=000, which precomputes the branch target.
  - Next state: R (not jr), addi, lui, lw, sw go to EXEC. beq and bne go to BRANCH. j, jal and jr go to JUMP. Illegal goes to ERR.
- EXEC: alu_src_a=1. alu_src_b=0 for R, 2 otherwise. alu_op per opcode.
  - Next state: lw goes to MEMRD, sw goes to MEMWR, all others go to WBALU.
- MEMRD / MEMWR: mem_req=1, iord=1. mem_we=1 in MEMWR only. Hold until mem_ready_i=1.
  - On ready, MEMRD goes to WBMEM and MEMWR goes to FETCH.
- WBALU: reg_write=1, mem_to_reg=0, reg_dst=1 for R and 0 for I-type. Next state is FETCH.
- WBMEM: reg_write=1, mem_to_reg=1, reg_dst=0. Next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op 100 for beq or 110 for bne, branch=1, pc_src=1, branch_type per opcode. Next state is FETCH.
- JUMP: pc_write=1. pc_src=3 for jr, 2 otherwise.
  - For jal, also assert reg_write=1, reg_dst=2, mem_to_reg=2. The PC already holds PC+4 at this point.
  - Next state is FETCH.
- ERR: all strobes 0. Stays in ERR until reset.

## Timing
- All outputs are Moore-decoded from the registered state, except that ir_write and pc_write in FETCH are also gated by mem_ready_i.
- Reset: rst_i=0 at a clock edge forces state=IDLE, clears illegal_o, timeout_o and the wait counter. This applies mid-instruction and mid-wait; any pending memory request is dropped.
- Every output is 0 after reset, and state_o=0.
- Cycle count per instruction with zero-wait memory (mem_ready_i high on the first request cycle):
  - R, addi, lui, sw: 4
  - lw: 5
  - beq, bne, j, jal, jr: 3
- Each wait cycle adds 1.
- Wait counter:
  - Width is $clog2(TIMEOUT+1).
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments on each cycle in which mem_req=1 and mem_ready_i=0.
  - When the counter reaches TIMEOUT with ready still low, the next state is ERR and timeout_o=1.
  - If ready and the limit arrive in the same cycle, ready wins.
- mem_ready_i outside a request is ignored.

## Structure
- Shared package ctrl_pkg holds:
  - opcode and funct localparams
  - state encodings
  - ALU-op, pc_src, alu_src_b, reg_dst and mem_to_reg encodings
- Natural sub-module: mc_wait_timer (wait counter and limit compare), parameterised by TIMEOUT.

## Test plan
- Reset then an R-type add with ready tied high: states 0→1→2→3→6→1, reg_write=1 and reg_dst=1 in the WBALU cycle.
- lw with 2 data wait cycles: MEMRD is held 3 cycles, mem_req=iord=1 throughout, then WBMEM with mem_to_reg=1. Total of 7 cycles from FETCH to the next FETCH.
- jal with EN_JAL=1: JUMP cycle shows pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2. With EN_JAL=0: ERR, illegal_o=1.
- bne: BRANCH cycle shows branch=1, branch_type=1, pc_src=1, alu_op=110. Then FETCH.
- Timeout with TIMEOUT=3 and ready held low in FETCH: ERR after 3 wait cycles, timeout_o=1 and sticky. rst_i=0 for one edge returns to IDLE with both flags 0.
- Reset asserted in MEMWR mid-wait: next cycle state=IDLE, mem_req=mem_we=0.
